change_dispenser: RTL
=====================

# change_dispenser

Change-return stage downstream of the vending `FSM`. It accepts the change amount the FSM computes after a drink is vended (e.g. 26 paid − 20 coffee = 6). It pays that amount out one coin at a time through a hopper handshake, using 10/5/1 denominations greedily. It tracks per-denomination tube inventory and reports any amount it could not pay.

## Interface

Parameters:
- `AMT_W`, 8, width of change amount (matches FSM `coin` width)
- `CNT_W`, 6, width of each tube counter
- `INIT_10`, 20, coins in the 10-tube after reset
- `INIT_5`, 20, coins in the 5-tube after reset
- `INIT_1`, 20, coins in the 1-tube after reset

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `change_valid`  in  1  change request from FSM
- `change_amount`  in  AMT_W  amount to return, unsigned
- `change_ready`  out  1  high when idle; a request is accepted on `change_valid & change_ready`
- `eject_valid`  out  1  hopper request to eject one coin
- `eject_denom`  out  2  coin to eject: 0 = 1, 1 = 5, 2 = 10
- `eject_ack`  in  1  hopper has ejected the coin
- `refill_valid`  in  1  add one coin to a tube
- `refill_denom`  in  2  tube to refill; same encoding as `eject_denom`; 3 = ignored
- `done`  out  1  one-cycle pulse when a request completes
- `shortfall`  out  AMT_W  unpaid remainder; valid while `done` = 1
- `cnt_10`, `cnt_5`, `cnt_1`  out  CNT_W each  current tube contents

## Operation

- States:
  - IDLE: `change_ready` = 1. On accept, latch `change_amount` into `remaining` and go to SELECT. `change_valid` in any other state is ignored.
  - SELECT: pick the largest d ∈ {10, 5, 1} with d ≤ `remaining` and tube(d) > 0.
    - `remaining` = 0 → DONE with shortfall 0.
    - No eligible d → DONE with shortfall = `remaining`.
    - Otherwise register `eject_denom` and go to EJECT.
  - EJECT: `eject_valid` = 1. `eject_denom` is held stable until `eject_ack`. On ack: tube(d) −1, `remaining` −d, go to SELECT.
  - DONE: `done` = 1 and `shortfall` driven for exactly one cycle, then IDLE. `shortfall` returns to 0 afterwards.
- Arithmetic:
  - `remaining` is AMT_W unsigned and never underflows, because d ≤ `remaining` is checked in SELECT.
  - Tube counters are CNT_W unsigned.
- Refill:
  - Accepted in any state; +1 to the selected tube, saturating at 2^CNT_W−1. A refill at saturation is dropped.
  - A refill and an ack-decrement on the same tube in the same cycle leave the count unchanged.
  - A refill on a different tube than the one being decremented applies independently.
- Greedy fallback when a tube is empty: a missing 10 is paid as 5+5. SELECT is re-evaluated for every coin.
- Reset mid-operation: the next cycle is IDLE. `eject_valid` = 0, `remaining` = 0, no `done` pulse, tubes = INIT values. A pending hopper ack is discarded.

## Timing

- Reset values:
  - `change_ready` = 1, `eject_valid` = 0, `eject_denom` = 0, `done` = 0, `shortfall` = 0
  - `cnt_10`/`cnt_5`/`cnt_1` = INIT_10/INIT_5/INIT_1
- Accept at edge T gives SELECT during cycle T+1. The first `eject_valid` is high in cycle T+2.
- Each coin costs 2 cycles minimum (SELECT + EJECT with same-cycle ack). Every extra cycle ack is withheld adds 1.
- After the final ack, the block spends 1 SELECT cycle, then asserts `done`. `change_ready` rises the cycle after `done`.
- Amount 0: `done` in cycle T+2, with no ejection.
- All outputs are registered or decoded from state only. There is no combinational path from `eject_ack` to `eject_valid`.

## Structure

- Shared package `vm_pkg`:
  - denomination encoding `DEN_1`/`DEN_5`/`DEN_10` and value constants 1/5/10
  - dispenser state enum
  - drink prices used by the FSM: tea 10, coke 15, coffee 20, milk 25
- Sub-module `coin_tube`: one saturating up/down counter with `inc`, `dec`, and init-value parameter. Instantiated three times.

## Test plan

- Full stock, request 6 → ejects 5 then 1; `done` with `shortfall` 0; `cnt_5` = 19, `cnt_1` = 19, `cnt_10` = 20.
- Full stock, request 26 with ack always high → ejects 10, 10, 5, 1; first `eject_valid` at T+2; `done` at T+10.
- INIT_10 = 0, request 26 → ejects five 5s then one 1; `cnt_5` = 15.
- INIT_10 = INIT_5 = 0, INIT_1 = 2, request 4 → two 1s; `done` with `shortfall` = 2; `cnt_1` = 0.
- Ack withheld 3 cycles → `eject_valid`/`eject_denom` stable throughout. A second `change_valid` during the request is ignored. Refill on the same tube during the ack cycle → count unchanged.
- Reset asserted in EJECT → next cycle `eject_valid` = 0, `change_ready` = 1, counts back to INIT, no `done`. Request 0 → `done` at T+2, `shortfall` 0.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin denominations, dispenser states and drink prices.
package vm_pkg;

    // Two-bit coin code shared by the hopper and the refill port; DEN_NONE is never ejected.
    localparam logic [1:0] DEN_1    = 2'd0;
    localparam logic [1:0] DEN_5    = 2'd1;
    localparam logic [1:0] DEN_10   = 2'd2;
    localparam logic [1:0] DEN_NONE = 2'd3;

    localparam int VAL_1  = 1;
    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;

    localparam int PRICE_TEA    = 10;
    localparam int PRICE_COKE   = 15;
    localparam int PRICE_COFFEE = 20;
    localparam int PRICE_MILK   = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_DONE
    } disp_state_e;

    function automatic int denomValue(input logic [1:0] den);
        case (den)
            DEN_1:   return VAL_1;
            DEN_5:   return VAL_5;
            DEN_10:  return VAL_10;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, hopper and refill signals of the change dispenser, plus tube-level readback.
interface change_dispenser_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 6
);
    logic             change_valid;
    logic [AMT_W-1:0] change_amount;
    logic             change_ready;
    logic             eject_valid;
    logic [1:0]       eject_denom;
    logic             eject_ack;
    logic             refill_valid;
    logic [1:0]       refill_denom;
    logic             done;
    logic [AMT_W-1:0] shortfall;
    logic [CNT_W-1:0] cnt_10;
    logic [CNT_W-1:0] cnt_5;
    logic [CNT_W-1:0] cnt_1;

    // The vending FSM / hopper side drives requests, acks and refills.
    modport master (
        output change_valid, change_amount, eject_ack, refill_valid, refill_denom,
        input  change_ready, eject_valid, eject_denom, done, shortfall,
               cnt_10, cnt_5, cnt_1
    );

    modport slave (
        input  change_valid, change_amount, eject_ack, refill_valid, refill_denom,
        output change_ready, eject_valid, eject_denom, done, shortfall,
               cnt_10, cnt_5, cnt_1
    );
endinterface

// File: rtl/coin_tube.sv
// One coin tube: saturating up/down counter; simultaneous inc and dec cancel out.
module coin_tube #(
    parameter int CNT_W = 6,
    parameter int INIT  = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A refill into a full tube is dropped; a decrement of an empty tube cannot happen
    // upstream but is still clamped so the counter never wraps.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= CNT_W'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount one coin at a time, greedily choosing 10/5/1 from whatever tubes are stocked.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W   = 8,
    parameter int CNT_W   = 6,
    parameter int INIT_10 = 20,
    parameter int INIT_5  = 20,
    parameter int INIT_1  = 20
) (
    input  logic         clk,
    input  logic         reset,
    change_dispenser_if.slave bus
);

    disp_state_e      state_q;
    logic [AMT_W-1:0] remaining_q;
    logic [1:0]       ejectDenom_q;
    logic             ejectValid_q;
    logic             done_q;
    logic [AMT_W-1:0] shortfall_q;
    logic             ready_q;

    logic [CNT_W-1:0] cnt10;
    logic [CNT_W-1:0] cnt5;
    logic [CNT_W-1:0] cnt1;

    logic             pickValid;
    logic [1:0]       pickDenom;
    logic [AMT_W-1:0] coinValue;
    logic             ackTaken;
    logic             dec10, dec5, dec1;
    logic             inc10, inc5, inc1;

    // Greedy choice: largest coin that fits the remainder and is actually in stock.
    always_comb begin
        pickValid = 1'b1;
        pickDenom = DEN_1;
        if (remaining_q >= AMT_W'(VAL_10) && cnt10 != '0) begin
            pickDenom = DEN_10;
        end else if (remaining_q >= AMT_W'(VAL_5) && cnt5 != '0) begin
            pickDenom = DEN_5;
        end else if (remaining_q >= AMT_W'(VAL_1) && cnt1 != '0) begin
            pickDenom = DEN_1;
        end else begin
            pickValid = 1'b0;
        end
    end

    always_comb begin
        coinValue = AMT_W'(denomValue(ejectDenom_q));
    end

    assign ackTaken = (state_q == ST_EJECT) && bus.eject_ack;
    assign dec10    = ackTaken && (ejectDenom_q == DEN_10);
    assign dec5     = ackTaken && (ejectDenom_q == DEN_5);
    assign dec1     = ackTaken && (ejectDenom_q == DEN_1);
    assign inc10    = bus.refill_valid && (bus.refill_denom == DEN_10);
    assign inc5     = bus.refill_valid && (bus.refill_denom == DEN_5);
    assign inc1     = bus.refill_valid && (bus.refill_denom == DEN_1);

    coin_tube #(.CNT_W(CNT_W), .INIT(INIT_10)) u_tube10 (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc10),
        .dec_i   (dec10),
        .count_o (cnt10)
    );

    coin_tube #(.CNT_W(CNT_W), .INIT(INIT_5)) u_tube5 (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc5),
        .dec_i   (dec5),
        .count_o (cnt5)
    );

    coin_tube #(.CNT_W(CNT_W), .INIT(INIT_1)) u_tube1 (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (inc1),
        .dec_i   (dec1),
        .count_o (cnt1)
    );

    // Every output is a register, so eject_ack can never reach eject_valid in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            ejectDenom_q <= DEN_1;
            ejectValid_q <= 1'b0;
            done_q       <= 1'b0;
            shortfall_q  <= '0;
            ready_q      <= 1'b1;
        end else begin
            done_q      <= 1'b0;
            shortfall_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.change_valid) begin
                        remaining_q <= bus.change_amount;
                        ready_q     <= 1'b0;
                        state_q     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (!pickValid) begin
                        done_q      <= 1'b1;
                        shortfall_q <= remaining_q;
                        state_q     <= ST_DONE;
                    end else begin
                        ejectDenom_q <= pickDenom;
                        ejectValid_q <= 1'b1;
                        state_q      <= ST_EJECT;
                    end
                end
                ST_EJECT: begin
                    if (bus.eject_ack) begin
                        remaining_q  <= remaining_q - coinValue;
                        ejectValid_q <= 1'b0;
                        state_q      <= ST_SELECT;
                    end
                end
                ST_DONE: begin
                    remaining_q <= '0;
                    ready_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    ejectValid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.change_ready = ready_q;
    assign bus.eject_valid  = ejectValid_q;
    assign bus.eject_denom  = ejectDenom_q;
    assign bus.done         = done_q;
    assign bus.shortfall    = shortfall_q;
    assign bus.cnt_10       = cnt10;
    assign bus.cnt_5        = cnt5;
    assign bus.cnt_1        = cnt1;

endmodule
